// File: rtl/ysyx_22050710_mem_pkg.sv
// rtl/ysyx_22050710_mem_pkg.sv - shared types and constants for the data-memory responder
package ysyx_22050710_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned WORD_OFF_W = 3;

  // Same base as the LSU and the simulator memory map.
  localparam logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050710_sram_bank.sv
// rtl/ysyx_22050710_sram_bank.sv - single-port 64-bit array with byte-lane writes and registered read
module ysyx_22050710_sram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [63:0]           wdata,
  input  logic [7:0]            wmask,
  output logic [63:0]           rdata
);

  logic [63:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < 8; k++) begin
          if (wmask[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/ysyx_22050710_dmem_resp.sv
// rtl/ysyx_22050710_dmem_resp.sv - latency-configurable data-memory slave for the LSU memory port
module ysyx_22050710_dmem_resp
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE       = DMEM_BASE,
  parameter int          LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err
);

  dmem_state_e           state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [63:0]           wdata_q;
  logic [7:0]            wmask_q;
  logic                  in_range_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  rd_sel_q;

  logic [63:0]           off;
  logic                  in_range;
  logic                  access;
  logic [63:0]           bank_rdata;
  logic                  unused_addr_lsb;

  // The lower-bound compare guards the subtraction, so addresses below BASE never wrap into range.
  assign off             = i_req_addr - BASE;
  assign in_range        = (i_req_addr >= BASE) &&
                           (off[63:DEPTH_LOG2+WORD_OFF_W] == '0);
  assign unused_addr_lsb = ^off[WORD_OFF_W-1:0];

  assign access       = (state_q == WAIT) && (cnt_q == 4'd0);
  assign o_req_ready  = (state_q == IDLE);
  assign o_resp_valid = valid_q;
  assign o_resp_err   = err_q;
  // The bank holds its read register while idle, so gating it keeps rdata stable through backpressure.
  assign o_resp_rdata = rd_sel_q ? bank_rdata : 64'd0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
      in_range_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            we_q       <= i_req_we;
            idx_q      <= off[DEPTH_LOG2+WORD_OFF_W-1:WORD_OFF_W];
            wdata_q    <= i_req_wdata;
            wmask_q    <= i_req_wmask;
            in_range_q <= in_range;
            cnt_q      <= 4'(LATENCY);
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (access) begin
            state_q  <= RESP;
            valid_q  <= 1'b1;
            err_q    <= !in_range_q;
            rd_sel_q <= in_range_q && !we_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ysyx_22050710_sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (i_clk),
    .en   (access && in_range_q),
    .we   (we_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_ysyx_22050710_dmem_resp.sv
// tb/tb_ysyx_22050710_dmem_resp.sv - bench for the data-memory responder at LATENCY 2 and 0
module tb_ysyx_22050710_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;

  logic        rq2, rv2, er2, rq0, rv0, er0;
  logic [63:0] rd2, rd0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  always #5 clk = ~clk;

  ysyx_22050710_dmem_resp #(.LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid & ~sel), .o_req_ready(rq2),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(rv2), .i_resp_ready(resp_ready & ~sel),
    .o_resp_rdata(rd2), .o_resp_err(er2)
  );

  ysyx_22050710_dmem_resp #(.LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid & sel), .o_req_ready(rq0),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(rv0), .i_resp_ready(resp_ready & sel),
    .o_resp_rdata(rd0), .o_resp_err(er0)
  );

  assign req_ready  = sel ? rq0 : rq2;
  assign resp_valid = sel ? rv0 : rv2;
  assign resp_rdata = sel ? rd0 : rd2;
  assign resp_err   = sel ? er0 : er2;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
  endtask

  task automatic scramble_req();
    req_valid = 1'b0;
    req_we    = ~req_we;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'hFF;
  endtask

  // Waits at negedges for resp_valid; k is the number of edges after acceptance edge T minus one.
  task automatic wait_resp(input int lat);
    int k;
    k = 0;
    while (!resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("resp_latency", 64'(k), 64'(lat + 1));
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input logic [63:0] erd, input logic eerr,
                     input int lat);
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    drive_req(we, addr, wdata, wmask);
    e.rdata = erd;
    e.err   = eerr;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    check("req_ready_busy", 64'(req_ready), 64'd0);
    wait_resp(lat);
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", 64'(resp_err), 64'(e.err));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   acc[$];
    logic seen;

    vecs[0]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0010, 64'hAA00_0000_0000_0000, 8'h80, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'hAA22_3344_5566_7788, 1'b0};
    vecs[4]  = '{1'b1, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 1'b0};
    vecs[5]  = '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[6]  = '{1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1};
    vecs[7]  = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 64'h8000_0000, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[9]  = '{1'b0, 64'h8000_0007, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 64'h8000_1FFF, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0102_0304_0506_0708, 1'b0};
    vecs[12] = '{1'b1, 64'h8000_0018, 64'h1111_1111_1111_1111, 8'hFF, 64'h0, 1'b0};
    vecs[13] = '{1'b1, 64'h8000_0018, 64'h2222_2222_2222_2222, 8'h55, 64'h0, 1'b0};
    vecs[14] = '{1'b0, 64'h8000_0018, 64'h0, 8'h00, 64'h1122_1122_1122_1122, 1'b0};

    sel        = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_wmask  = 8'd0;
    resp_ready = 1'b0;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rdata, vecs[i].err, 2);
    end

    // Backpressure: response must hold and a new request must stay unaccepted.
    @(negedge clk);
    drive_req(1'b0, 64'h8000_0010, 64'd0, 8'd0);
    e.rdata = 64'hAA22_3344_5566_7788;
    e.err   = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    wait_resp(2);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_rdata", resp_rdata, e.rdata);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      drive_req(1'b1, 64'h8000_0010, 64'd0, 8'hFF);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    txn(1'b0, 64'h8000_0010, 64'd0, 8'd0, 64'hAA22_3344_5566_7788, 1'b0, 2);

    // Reset while a write sits in WAIT: no response, array untouched.
    @(negedge clk);
    drive_req(1'b1, 64'h8000_0010, 64'd0, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    txn(1'b0, 64'h8000_0010, 64'd0, 8'd0, 64'hAA22_3344_5566_7788, 1'b0, 2);

    // Zero-latency instance.
    sel = 1'b1;
    txn(1'b1, 64'h8000_0008, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 64'h0, 1'b0, 0);
    txn(1'b0, 64'h8000_0008, 64'd0, 8'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 0);
    txn(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 8'd0, 64'h0, 1'b1, 0);
    txn(1'b0, 64'h0000_0001_8000_0010, 64'd0, 8'd0, 64'h0, 1'b1, 0);

    @(negedge clk);
    drive_req(1'b0, 64'h8000_0008, 64'd0, 8'd0);
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready && req_valid) acc.push_back(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready = 1'b0;
    check("tput_gap", (acc.size() >= 2) ? 64'(acc[1] - acc[0]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    check("tput_idle", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
